// File: rtl/multicyc_exec_pkg.sv
// Shared CPU package slice: operation encodings, multi-cycle unit state and helpers.
// Op classification here is independent of MULTICYC_MADD_EN; the top decides what is multi-cycle.
package multicyc_exec_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [63:0] uint64_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MUL   = 4'd1,
        OP_MULT  = 4'd2,
        OP_MULTU = 4'd3,
        OP_DIV   = 4'd4,
        OP_DIVU  = 4'd5,
        OP_MTHI  = 4'd6,
        OP_MTLO  = 4'd7,
        OP_MADD  = 4'd8,
        OP_MADDU = 4'd9,
        OP_MSUB  = 4'd10,
        OP_MSUBU = 4'd11
    } oper_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } multicyc_state_t;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

    function automatic logic is_mul_op(input oper_t o);
        return (o == OP_MUL) || (o == OP_MULT) || (o == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input oper_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_acc_op(input oper_t o);
        return (o == OP_MADD) || (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU);
    endfunction

    function automatic logic is_signed_op(input oper_t o);
        return (o == OP_MUL) || (o == OP_MULT) || (o == OP_DIV) ||
               (o == OP_MADD) || (o == OP_MSUB);
    endfunction

endpackage

// File: rtl/multicyc_exec_div_iter.sv
// 32-step restoring unsigned divider, one quotient bit per cycle after start.
// quot/rem carry the final values combinationally in the cycle done is high.
module div_iter
    import multicyc_exec_pkg::*;
#(
    parameter int unsigned ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
        ge      = ~trial[XLEN];
        rem     = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quot    = {quot_q[XLEN-2:0], ge};
        done    = busy_q && (cnt_q == CNT_W'(ITERS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem;
            quot_q <= quot;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicyc_exec.sv
// Multi-cycle MUL/MULT(U)/DIV(U) unit beside EX; MTHI/MTLO pass through combinationally.
// MULTICYC_MADD_EN makes MADD(U)/MSUB(U) multi-cycle accumulate ops; otherwise they pass hilo_i.
module multicyc_exec
    import multicyc_exec_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_ITER   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            valid,
    input  oper_t           op,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  uint64_t         hilo_i,
    input  logic            pipe_stall,
    output logic            stall,
    output uint64_t         hilo_o,
    output logic [XLEN-1:0] reg_o
);

    localparam int unsigned CNT_W = 8;

    multicyc_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  a_q, b_q;
    uint64_t          acc_q;
    oper_t            op_q;
    uint64_t          hilo_q;
    logic [XLEN-1:0]  reg_q;

    logic             multi_c, passthru_c, issue_c, in_idle;
    oper_t            src_op;
    logic [XLEN-1:0]  src_a, src_b;
    uint64_t          src_acc, ext_a, ext_b, prod, mul_res, res_hilo;
    logic [CNT_W-1:0] mul_target, cnt_inc;
    logic             load_res, wr_reg;

    logic             div_start, div_done, div_signed_q;
    logic [XLEN-1:0]  mag_a, mag_b, div_quot, div_rem, quot_fix, rem_fix;

`ifdef MULTICYC_MADD_EN
    assign multi_c    = is_mul_op(op) | is_div_op(op) | is_acc_op(op);
    assign passthru_c = 1'b0;
`else
    assign multi_c    = is_mul_op(op) | is_div_op(op);
    assign passthru_c = is_acc_op(op);
`endif

    // rst_n gates the start so stall reads 0 while reset is held
    assign in_idle = (state_q == ST_IDLE);
    assign issue_c = in_idle && rst_n && valid && multi_c && !flush;

    // Operands come live from EX at issue, from the latches afterwards
    assign src_op  = in_idle ? op     : op_q;
    assign src_a   = in_idle ? reg1   : a_q;
    assign src_b   = in_idle ? reg2   : b_q;
    assign src_acc = in_idle ? hilo_i : acc_q;

    always_comb begin
        ext_a = is_signed_op(src_op) ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
        ext_b = is_signed_op(src_op) ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
        prod  = ext_a * ext_b;
        if ((src_op == OP_MSUB) || (src_op == OP_MSUBU)) begin
            mul_res = src_acc - prod;
        end else if ((src_op == OP_MADD) || (src_op == OP_MADDU)) begin
            mul_res = src_acc + prod;
        end else begin
            mul_res = prod;
        end
        mul_target = is_acc_op(src_op) ? CNT_W'(MUL_CYCLES + 1) : CNT_W'(MUL_CYCLES);
        cnt_inc    = cnt_q + CNT_W'(1);
    end

    // Divider runs on magnitudes; sign fix uses the latched operands
    assign mag_a     = ((op == OP_DIV) && reg1[XLEN-1]) ? (~reg1 + 32'd1) : reg1;
    assign mag_b     = ((op == OP_DIV) && reg2[XLEN-1]) ? (~reg2 + 32'd1) : reg2;
    assign div_start = issue_c && is_div_op(op);
    assign div_signed_q = (op_q == OP_DIV);

    div_iter #(.ITERS(DIV_ITER)) u_div_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_comb begin
        if (b_q == '0) begin
            quot_fix = DIV_BY_ZERO_QUOT;
        end else if (div_signed_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) begin
            quot_fix = ~div_quot + 32'd1;
        end else begin
            quot_fix = div_quot;
        end
        rem_fix = (div_signed_q && a_q[XLEN-1]) ? (~div_rem + 32'd1) : div_rem;
    end

    // Next state, stall and result-load strobes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        load_res = 1'b0;
        wr_reg   = 1'b0;
        res_hilo = mul_res;
        case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    stall = 1'b1;
                    if (is_div_op(op)) begin
                        state_d = ST_DIV_BUSY;
                        cnt_d   = '0;
                    end else if (mul_target == CNT_W'(1)) begin
                        state_d  = ST_DONE;
                        load_res = 1'b1;
                        wr_reg   = 1'b1;
                    end else begin
                        state_d = ST_MUL_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_MUL_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc == mul_target) begin
                    state_d  = ST_DONE;
                    load_res = 1'b1;
                    wr_reg   = 1'b1;
                end
            end
            ST_DIV_BUSY: begin
                stall = 1'b1;
                if (div_done) begin
                    state_d  = ST_DONE;
                    load_res = 1'b1;
                    res_hilo = {rem_fix, quot_fix};
                end
            end
            ST_DONE: begin
                if (!pipe_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            load_res = 1'b0;
            wr_reg   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            op_q    <= OP_NOP;
            hilo_q  <= '0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue_c) begin
                a_q   <= reg1;
                b_q   <= reg2;
                acc_q <= hilo_i;
                op_q  <= op;
            end
            if (load_res) begin
                hilo_q <= res_hilo;
            end
            if (wr_reg) begin
                reg_q <= prod[XLEN-1:0];
            end
        end
    end

    // Single-cycle HI/LO moves bypass the result register
    always_comb begin
        hilo_o = hilo_q;
        if (in_idle) begin
            if (op == OP_MTHI) begin
                hilo_o = {reg1, hilo_i[XLEN-1:0]};
            end else if (op == OP_MTLO) begin
                hilo_o = {hilo_i[2*XLEN-1:XLEN], reg1};
            end else if (passthru_c) begin
                hilo_o = hilo_i;
            end
        end
    end

    assign reg_o = reg_q;

endmodule
